// File: rtl/instmem_loader.sv
// Program loader: assembles a framed big-endian byte stream into 16-bit words,
// writes them to instruction memory from address 0, then restarts the processor.
module instmem_loader #(
   parameter int ADDR_W         = 6,
   parameter int DATA_W         = 16,
   parameter int DEPTH          = 64,
   parameter int RESTART_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [7:0]        byte_in,
   input  logic              byte_valid,
   output logic              byte_ready,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic              hold_proc,
   output logic              restart_out,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [6:0]        word_count
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LEN     = 3'd1,
      HI      = 3'd2,
      LO      = 3'd3,
      CSUM    = 3'd4,
      RESTART = 3'd5,
      DONE    = 3'd6,
      ERR     = 3'd7
   } state_t;

   localparam logic [7:0] RC_LAST = 8'(RESTART_CYCLES - 1);
   localparam logic [7:0] DEPTH_B = 8'(DEPTH);

   state_t      state;
   state_t      state_nxt;
   logic        accept;
   logic        load_start;
   logic        len_ok;
   logic [7:0]  hi_byte;
   logic [7:0]  csum;
   logic [6:0]  n_len;
   logic [7:0]  rcnt;
   logic [6:0]  count_inc;

   assign accept     = byte_valid && byte_ready;
   assign load_start = start && (state == IDLE || state == DONE || state == ERR);
   assign len_ok     = (byte_in != 8'd0) && (byte_in <= DEPTH_B);
   assign count_inc  = word_count + 7'd1;

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, DONE, ERR: begin
            if (load_start) state_nxt = LEN;
         end
         LEN: begin
            if (accept) state_nxt = len_ok ? HI : ERR;
         end
         HI: begin
            if (accept) state_nxt = LO;
         end
         LO: begin
            if (accept) state_nxt = (count_inc < n_len) ? HI : CSUM;
         end
         CSUM: begin
            if (accept) state_nxt = (byte_in == csum) ? RESTART : ERR;
         end
         RESTART: begin
            if (rcnt == RC_LAST) state_nxt = DONE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs decoded from state; ERR keeps the processor held so a corrupt program never runs
   always_comb begin
      byte_ready  = 1'b0;
      hold_proc   = 1'b0;
      restart_out = 1'b0;
      busy        = 1'b0;
      done        = 1'b0;
      err         = 1'b0;
      case (state)
         LEN, HI, LO, CSUM: begin
            byte_ready = 1'b1;
            hold_proc  = 1'b1;
            busy       = 1'b1;
         end
         RESTART: begin
            restart_out = 1'b1;
            hold_proc   = 1'b1;
            busy        = 1'b1;
         end
         DONE: done = 1'b1;
         ERR: begin
            err       = 1'b1;
            hold_proc = 1'b1;
         end
         default: ;
      endcase
   end

   // Datapath: word assembly, write strobe, checksum and counters
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_en      <= 1'b0;
         wr_addr    <= '0;
         wr_data    <= '0;
         word_count <= '0;
         hi_byte    <= '0;
         csum       <= '0;
         n_len      <= '0;
         rcnt       <= '0;
      end else begin
         wr_en <= 1'b0;
         case (state)
            IDLE, DONE, ERR: begin
               if (load_start) begin
                  word_count <= '0;
                  csum       <= '0;
                  wr_addr    <= '0;
                  rcnt       <= '0;
               end
            end
            LEN: begin
               if (accept) n_len <= byte_in[6:0];
            end
            HI: begin
               if (accept) begin
                  hi_byte <= byte_in;
                  csum    <= csum ^ byte_in;
               end
            end
            LO: begin
               if (accept) begin
                  wr_data    <= DATA_W'({hi_byte, byte_in});
                  wr_addr    <= word_count[ADDR_W-1:0];
                  wr_en      <= 1'b1;
                  csum       <= csum ^ byte_in;
                  word_count <= count_inc;
               end
            end
            CSUM: begin
               if (accept) rcnt <= '0;
            end
            RESTART: rcnt <= rcnt + 8'd1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_instmem_loader.sv
// Directed bench for instmem_loader: framed loads, checksum and length errors,
// stalls, asynchronous reset mid-frame and ignored start.
module tb_instmem_loader;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [7:0]  byte_in;
   logic        byte_valid;
   logic        byte_ready;
   logic        wr_en;
   logic [5:0]  wr_addr;
   logic [15:0] wr_data;
   logic        hold_proc;
   logic        restart_out;
   logic        busy;
   logic        done;
   logic        err;
   logic [6:0]  word_count;

   int total = 0;
   int bad   = 0;

   // monitor-owned counters and write log
   int          cyc = 0;
   int          wcnt = 0;
   int          rs_cnt = 0;
   int          rs_rdy = 0;
   int          acc_cnt = 0;
   logic [5:0]  wa [0:255];
   logic [15:0] wd [0:255];
   int          wc [0:255];

   instmem_loader dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .byte_in     (byte_in),
      .byte_valid  (byte_valid),
      .byte_ready  (byte_ready),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .hold_proc   (hold_proc),
      .restart_out (restart_out),
      .busy        (busy),
      .done        (done),
      .err         (err),
      .word_count  (word_count)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      cyc = cyc + 1;
      if (wr_en) begin
         if (wcnt < 256) begin
            wa[wcnt] = wr_addr;
            wd[wcnt] = wr_data;
            wc[wcnt] = cyc;
         end
         wcnt = wcnt + 1;
      end
      if (restart_out) rs_cnt = rs_cnt + 1;
      if (restart_out && byte_ready) rs_rdy = rs_rdy + 1;
      if (byte_valid && byte_ready) acc_cnt = acc_cnt + 1;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int stall);
      int   n = 0;
      logic rdy;
      for (int i = 0; i < stall; i++) begin
         @(posedge clk);
         #1;
      end
      byte_in    = b;
      byte_valid = 1'b1;
      do begin
         @(negedge clk);
         rdy = byte_ready;
         @(posedge clk);
         #1;
         n++;
      end while (!rdy && n < 50);
      byte_valid = 1'b0;
      if (!rdy) begin
         total++;
         bad++;
         $display("FAIL send_byte: byte %h never accepted, got ready=0 want ready=1", b);
      end
   endtask

   task automatic send_good_frame();
      send_byte(8'h02, 0);
      send_byte(8'h12, 0);
      send_byte(8'h34, 0);
      send_byte(8'hAB, 0);
      send_byte(8'hCD, 0);
      send_byte(8'h40, 0);
   endtask

   task automatic wait_end();
      int n = 0;
      while (!(done || err) && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!(done || err)) begin
         total++;
         bad++;
         $display("FAIL wait_end: load never finished, got done=%b err=%b want one set", done, err);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst        = 1'b0;
      start      = 1'b0;
      byte_in    = 8'h00;
      byte_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      total++;
      if ({byte_ready, wr_en, wr_addr, wr_data, hold_proc, restart_out, busy, done, err, word_count} !== 37'd0) begin
         bad++;
         $display("FAIL reset_outputs: got %h want 0",
                  {byte_ready, wr_en, wr_addr, wr_data, hold_proc, restart_out, busy, done, err, word_count});
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
      total++;
      if (byte_ready !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL idle_ready: got ready=%b busy=%b want 0 0", byte_ready, busy);
      end
   endtask

   task automatic test_good_load();
      int w0  = wcnt;
      int rs0 = rs_cnt;
      int rr0 = rs_rdy;
      pulse_start();
      total++;
      if (busy !== 1'b1 || hold_proc !== 1'b1 || byte_ready !== 1'b1) begin
         bad++;
         $display("FAIL good_start: got busy=%b hold=%b ready=%b want 1 1 1", busy, hold_proc, byte_ready);
      end
      send_byte(8'h02, 0);
      send_byte(8'h12, 0);
      send_byte(8'h34, 0);
      total++;
      if (wr_en !== 1'b1 || wr_addr !== 6'h00 || wr_data !== 16'h1234) begin
         bad++;
         $display("FAIL good_write0: got en=%b addr=%h data=%h want 1 00 1234", wr_en, wr_addr, wr_data);
      end
      send_byte(8'hAB, 0);
      total++;
      if (wr_en !== 1'b0 || wr_data !== 16'h1234) begin
         bad++;
         $display("FAIL good_strobe_len: got en=%b data=%h want 0 1234", wr_en, wr_data);
      end
      send_byte(8'hCD, 0);
      send_byte(8'h40, 0);
      wait_end();
      total++;
      if (wcnt - w0 !== 2 || wa[w0] !== 6'h00 || wd[w0] !== 16'h1234 || wa[w0+1] !== 6'h01 || wd[w0+1] !== 16'hABCD) begin
         bad++;
         $display("FAIL good_writes: got n=%0d %h:%h %h:%h want 2 00:1234 01:abcd",
                  wcnt - w0, wa[w0], wd[w0], wa[w0+1], wd[w0+1]);
      end
      total++;
      if (wc[w0+1] - wc[w0] !== 2) begin
         bad++;
         $display("FAIL back_to_back: got spacing %0d want 2", wc[w0+1] - wc[w0]);
      end
      total++;
      if (rs_cnt - rs0 !== 2 || rs_rdy !== rr0) begin
         bad++;
         $display("FAIL good_restart: got width=%0d ready_hits=%0d want 2 0", rs_cnt - rs0, rs_rdy - rr0);
      end
      total++;
      if (done !== 1'b1 || err !== 1'b0 || hold_proc !== 1'b0 || busy !== 1'b0 || word_count !== 7'd2) begin
         bad++;
         $display("FAIL good_final: got done=%b err=%b hold=%b busy=%b cnt=%0d want 1 0 0 0 2",
                  done, err, hold_proc, busy, word_count);
      end
   endtask

   task automatic test_bad_csum();
      int w0  = wcnt;
      int rs0 = rs_cnt;
      pulse_start();
      total++;
      if (done !== 1'b0) begin
         bad++;
         $display("FAIL done_clear: got done=%b want 0", done);
      end
      send_byte(8'h02, 0);
      send_byte(8'h12, 0);
      send_byte(8'h34, 0);
      send_byte(8'hAB, 0);
      send_byte(8'hCD, 0);
      send_byte(8'h41, 0);
      wait_end();
      total++;
      if (wcnt - w0 !== 2 || wd[w0+1] !== 16'hABCD) begin
         bad++;
         $display("FAIL bad_csum_writes: got n=%0d data=%h want 2 abcd", wcnt - w0, wd[w0+1]);
      end
      total++;
      if (err !== 1'b1 || done !== 1'b0 || hold_proc !== 1'b1 || busy !== 1'b0 || rs_cnt !== rs0) begin
         bad++;
         $display("FAIL bad_csum_state: got err=%b done=%b hold=%b busy=%b restarts=%0d want 1 0 1 0 0",
                  err, done, hold_proc, busy, rs_cnt - rs0);
      end
   endtask

   task automatic test_len_bounds();
      int         w0;
      logic [7:0] h;
      logic [7:0] l;
      logic [7:0] cs;
      w0 = wcnt;
      pulse_start();
      send_byte(8'h00, 0);
      total++;
      if (err !== 1'b1 || busy !== 1'b0 || wcnt !== w0) begin
         bad++;
         $display("FAIL len_zero: got err=%b busy=%b writes=%0d want 1 0 0", err, busy, wcnt - w0);
      end
      pulse_start();
      send_byte(8'h41, 0);
      total++;
      if (err !== 1'b1 || wcnt !== w0) begin
         bad++;
         $display("FAIL len_65: got err=%b writes=%0d want 1 0", err, wcnt - w0);
      end
      pulse_start();
      cs = 8'h00;
      send_byte(8'h40, 0);
      for (int i = 0; i < 64; i++) begin
         h = 8'(i);
         l = 8'(i * 3 + 1);
         send_byte(h, 0);
         send_byte(l, 0);
         cs = cs ^ h ^ l;
      end
      send_byte(cs, 0);
      wait_end();
      total++;
      if (wcnt - w0 !== 64 || wa[w0+63] !== 6'h3F || wd[w0+63] !== 16'h3FBE || wa[w0+32] !== 6'h20 || wd[w0+32] !== 16'h2061) begin
         bad++;
         $display("FAIL len_64_writes: got n=%0d last=%h:%h mid=%h:%h want 64 3f:3fbe 20:2061",
                  wcnt - w0, wa[w0+63], wd[w0+63], wa[w0+32], wd[w0+32]);
      end
      total++;
      if (done !== 1'b1 || err !== 1'b0 || word_count !== 7'd64) begin
         bad++;
         $display("FAIL len_64_final: got done=%b err=%b cnt=%0d want 1 0 64", done, err, word_count);
      end
   endtask

   task automatic test_stall();
      int          w0;
      int          a0;
      logic [7:0]  fr [0:7];
      fr[0] = 8'h03; fr[1] = 8'h11; fr[2] = 8'h22; fr[3] = 8'h33;
      fr[4] = 8'h44; fr[5] = 8'h55; fr[6] = 8'h66; fr[7] = 8'h77;
      rst = 1'b0;
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      a0 = acc_cnt;
      byte_in    = 8'h55;
      byte_valid = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if (byte_ready !== 1'b0 || acc_cnt !== a0) begin
         bad++;
         $display("FAIL idle_no_accept: got ready=%b accepted=%0d want 0 0", byte_ready, acc_cnt - a0);
      end
      byte_valid = 1'b0;
      w0 = wcnt;
      a0 = acc_cnt;
      pulse_start();
      for (int i = 0; i < 8; i++) send_byte(fr[i], int'($urandom_range(0, 3)));
      wait_end();
      total++;
      if (acc_cnt - a0 !== 8) begin
         bad++;
         $display("FAIL stall_accepts: got %0d want 8", acc_cnt - a0);
      end
      total++;
      if (wcnt - w0 !== 3 || wd[w0] !== 16'h1122 || wd[w0+1] !== 16'h3344 || wd[w0+2] !== 16'h5566 || wa[w0+2] !== 6'h02) begin
         bad++;
         $display("FAIL stall_writes: got n=%0d %h %h %h@%h want 3 1122 3344 5566@02",
                  wcnt - w0, wd[w0], wd[w0+1], wd[w0+2], wa[w0+2]);
      end
      total++;
      if (done !== 1'b1 || word_count !== 7'd3) begin
         bad++;
         $display("FAIL stall_final: got done=%b cnt=%0d want 1 3", done, word_count);
      end
   endtask

   task automatic test_reset_mid();
      int w0;
      pulse_start();
      send_byte(8'h03, 0);
      send_byte(8'h01, 0);
      send_byte(8'h02, 0);
      send_byte(8'h03, 0);
      total++;
      if (wr_data !== 16'h0102 || word_count !== 7'd1 || hold_proc !== 1'b1) begin
         bad++;
         $display("FAIL pre_reset: got data=%h cnt=%0d hold=%b want 0102 1 1", wr_data, word_count, hold_proc);
      end
      #1;
      rst = 1'b0;
      #1;
      total++;
      if ({byte_ready, wr_en, wr_addr, wr_data, hold_proc, restart_out, busy, done, err, word_count} !== 37'd0) begin
         bad++;
         $display("FAIL async_reset: got %h want 0",
                  {byte_ready, wr_en, wr_addr, wr_data, hold_proc, restart_out, busy, done, err, word_count});
      end
      @(posedge clk);
      #1;
      rst = 1'b1;
      w0 = wcnt;
      pulse_start();
      send_good_frame();
      wait_end();
      total++;
      if (wcnt - w0 !== 2 || wa[w0] !== 6'h00 || wd[w0] !== 16'h1234 || wd[w0+1] !== 16'hABCD || done !== 1'b1) begin
         bad++;
         $display("FAIL reload_after_reset: got n=%0d %h:%h %h done=%b want 2 00:1234 abcd 1",
                  wcnt - w0, wa[w0], wd[w0], wd[w0+1], done);
      end
   endtask

   task automatic test_start_ignored();
      int w0 = wcnt;
      pulse_start();
      send_byte(8'h02, 0);
      pulse_start();
      total++;
      if (busy !== 1'b1 || byte_ready !== 1'b1 || word_count !== 7'd0) begin
         bad++;
         $display("FAIL start_in_hi: got busy=%b ready=%b cnt=%0d want 1 1 0", busy, byte_ready, word_count);
      end
      send_byte(8'h12, 0);
      send_byte(8'h34, 0);
      send_byte(8'hAB, 0);
      send_byte(8'hCD, 0);
      send_byte(8'h40, 0);
      wait_end();
      total++;
      if (done !== 1'b1 || err !== 1'b0 || wcnt - w0 !== 2 || wd[w0] !== 16'h1234) begin
         bad++;
         $display("FAIL start_ignored_final: got done=%b err=%b n=%0d data=%h want 1 0 2 1234",
                  done, err, wcnt - w0, wd[w0]);
      end
   endtask

   initial begin
      test_reset();
      test_good_load();
      test_bad_csum();
      test_len_bounds();
      test_stall();
      test_reset_mid();
      test_start_ignored();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
